// File: rtl/elevator_shaft_model.sv
// Three-floor elevator car and door plant model.
// Answers controller door/dir commands with dc/fs sensors and sticky faults.
module elevator_shaft_model #(
  parameter int TRAVEL_CYCLES = 8,
  parameter int DOOR_CYCLES   = 4,
  parameter int RESET_FLOOR   = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       door,
  input  logic [1:0] dir,
  input  logic       fault_clr,
  output logic       dc,
  output logic [1:0] fs,
  output logic       moving,
  output logic [2:0] fault
);

  localparam int PW = $clog2(2*TRAVEL_CYCLES+1);
  localparam int DW = $clog2(DOOR_CYCLES+1);

  localparam logic [PW-1:0] F2 = PW'(TRAVEL_CYCLES);
  localparam logic [PW-1:0] F3 = PW'(2*TRAVEL_CYCLES);
  localparam logic [PW-1:0] RST_POS =
    PW'((RESET_FLOOR-1)*TRAVEL_CYCLES);
  localparam logic [DW-1:0] DMAX = DW'(DOOR_CYCLES);

  typedef enum logic [1:0] {
    CLOSED,
    OPENING,
    OPEN,
    CLOSING
  } door_st_e;

  door_st_e        state_q, state_d;
  logic [PW-1:0]   pos_q, pos_d;
  logic [DW-1:0]   dpos_q, dpos_d;
  logic            mov_d;
  logic [2:0]      set_f;
  logic [2:0]      fault_d;
  logic            door_go;

  function automatic logic [1:0] fcode(input logic [PW-1:0] p);
    logic [1:0] c;
    c = 2'b00;
    unique case (1'b1)
      (p == '0): c = 2'b01;
      (p == F2): c = 2'b10;
      (p == F3): c = 2'b11;
      default:   c = 2'b00;
    endcase
    return c;
  endfunction

  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    dpos_d  = dpos_q;
    mov_d   = 1'b0;
    set_f   = 3'b000;
    door_go = 1'b0;

    if (dir == 2'b11) set_f[2] = 1'b1;

    unique case (state_q)
      CLOSED: begin
        door_go = door && (fs != 2'b00);
        if (door && (fs == 2'b00)) set_f[2] = 1'b1;
        if (door_go) begin
          // Door wins over a simultaneous motion request.
          if (dir != 2'b00) set_f[0] = 1'b1;
          dpos_d  = dpos_q + DW'(1);
          state_d = (dpos_d == DMAX) ? OPEN : OPENING;
        end else begin
          unique case (dir)
            2'b01: begin
              if (pos_q < F3) begin
                pos_d = pos_q + PW'(1);
                mov_d = 1'b1;
              end else begin
                set_f[1] = 1'b1;
              end
            end
            2'b10: begin
              if (pos_q != '0) begin
                pos_d = pos_q - PW'(1);
                mov_d = 1'b1;
              end else begin
                set_f[1] = 1'b1;
              end
            end
            default: ;
          endcase
        end
      end
      OPENING, CLOSING: begin
        if (dir != 2'b00) set_f[0] = 1'b1;
        if (door) begin
          dpos_d  = dpos_q + DW'(1);
          state_d = (dpos_d == DMAX) ? OPEN : OPENING;
        end else begin
          dpos_d  = dpos_q - DW'(1);
          state_d = (dpos_d == '0) ? CLOSED : CLOSING;
        end
      end
      OPEN: begin
        if (dir != 2'b00) set_f[0] = 1'b1;
        if (!door) begin
          dpos_d  = dpos_q - DW'(1);
          state_d = (dpos_d == '0) ? CLOSED : CLOSING;
        end
      end
      default: ;
    endcase

    fault_d = (fault_clr ? 3'b000 : fault) | set_f;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= CLOSED;
      pos_q   <= RST_POS;
      dpos_q  <= '0;
      dc      <= 1'b1;
      fs      <= fcode(RST_POS);
      moving  <= 1'b0;
      fault   <= 3'b000;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      dpos_q  <= dpos_d;
      dc      <= (state_d == CLOSED);
      fs      <= fcode(pos_d);
      moving  <= mov_d;
      fault   <= fault_d;
    end
  end

endmodule
